// File: rtl/piece_selector.sv
// piece_selector: push-button driven piece-type selector.
//
// A raw button is synchronised, debounced and rising-edge detected. Each
// accepted press moves the preview piece into the current slot and computes
// a new preview. Advance is sequential (up/down, wrapping) or pseudo-random
// with no immediate repeats. A load request forces the current piece.
//
// Ports:
//   clk          system clock, rising edge
//   rst_i        synchronous active-high reset
//   button_i     raw asynchronous push-button level
//   dir_i        sequential direction: 0 = up, 1 = down
//   mode_i       0 = sequential, 1 = random
//   load_i       one-cycle request to force the current selection
//   load_val_i   value to load (clamped to N_TYPES-1)
//   sel_o        current piece index
//   preview_o    next piece index
//   step_o       one-cycle pulse on the first cycle of a press-advanced sel_o
//   press_cnt_o  saturating count of accepted presses
module piece_selector #(
  parameter int          N_TYPES   = 7,
  parameter int          DEBOUNCE  = 4,
  parameter int          CNT_W     = 8,
  parameter logic [7:0]  LFSR_SEED = 8'hA5,
  localparam int         SEL_W     = $clog2(N_TYPES)
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             button_i,
  input  logic             dir_i,
  input  logic             mode_i,
  input  logic             load_i,
  input  logic [SEL_W-1:0] load_val_i,
  output logic [SEL_W-1:0] sel_o,
  output logic [SEL_W-1:0] preview_o,
  output logic             step_o,
  output logic [CNT_W-1:0] press_cnt_o
);

  localparam int               DB_W     = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);
  localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_TYPES - 1);
  localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
  localparam logic [SEL_W:0]   N_EXT    = (SEL_W + 1)'(N_TYPES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q, sync1_d;
  logic             btn_s_q, btn_s_d;
  logic             btn_stable_q, btn_stable_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] preview_q, preview_d;
  logic             step_q, step_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic             press;
  logic [SEL_W-1:0] load_clamped;

  // Successor of piece p under the given mode/direction. In random mode the
  // LFSR candidate is folded into range with one subtraction (it is always
  // below 2*N_TYPES), then bumped by one if it would repeat p.
  function automatic logic [SEL_W-1:0] next_piece(input logic [SEL_W-1:0] p,
                                                  input logic             mode,
                                                  input logic             dir,
                                                  input logic [7:0]       lfsr);
    logic [SEL_W:0]   cand;
    logic [SEL_W-1:0] r;
    if (mode) begin
      cand = {1'b0, lfsr[SEL_W-1:0]};
      if (cand >= N_EXT) cand = cand - N_EXT;
      r = cand[SEL_W-1:0];
      if (r == p) r = (r == SEL_LAST) ? '0 : r + SEL_ONE;
    end else if (!dir) begin
      r = (p == SEL_LAST) ? '0 : p + SEL_ONE;
    end else begin
      r = (p == '0) ? SEL_LAST : p - SEL_ONE;
    end
    return r;
  endfunction

  function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] v);
    return (v > SEL_LAST) ? SEL_LAST : v;
  endfunction

  always_comb begin
    // Stage: two-flop synchroniser
    sync1_d = button_i;
    btn_s_d = sync1_q;

    // Stage: debounce; a press is the edge where the stable level rises
    btn_stable_d = btn_stable_q;
    db_cnt_d     = db_cnt_q;
    press        = 1'b0;
    if (btn_s_q == btn_stable_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      btn_stable_d = btn_s_q;
      db_cnt_d     = '0;
      press        = btn_s_q;
    end else begin
      db_cnt_d = db_cnt_q + DB_ONE;
    end

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, free-running
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // Stage: selection update; load wins over a coincident press
    load_clamped = clamp_sel(load_val_i);
    sel_d        = sel_q;
    preview_d    = preview_q;
    step_d       = 1'b0;
    press_cnt_d  = press_cnt_q;
    if (load_i) begin
      sel_d     = load_clamped;
      preview_d = next_piece(load_clamped, mode_i, dir_i, lfsr_q);
    end else if (press) begin
      sel_d     = preview_q;
      preview_d = next_piece(preview_q, mode_i, dir_i, lfsr_q);
      step_d    = 1'b1;
      if (press_cnt_q != '1) press_cnt_d = press_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      sync1_q      <= 1'b0;
      btn_s_q      <= 1'b0;
      btn_stable_q <= 1'b0;
      db_cnt_q     <= '0;
      lfsr_q       <= LFSR_SEED;
      sel_q        <= '0;
      preview_q    <= SEL_ONE;
      step_q       <= 1'b0;
      press_cnt_q  <= '0;
    end else begin
      sync1_q      <= sync1_d;
      btn_s_q      <= btn_s_d;
      btn_stable_q <= btn_stable_d;
      db_cnt_q     <= db_cnt_d;
      lfsr_q       <= lfsr_d;
      sel_q        <= sel_d;
      preview_q    <= preview_d;
      step_q       <= step_d;
      press_cnt_q  <= press_cnt_d;
    end
  end

  assign sel_o       = sel_q;
  assign preview_o   = preview_q;
  assign step_o      = step_q;
  assign press_cnt_o = press_cnt_q;

endmodule
